// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction stage: FSM state encoding
// and the credit-width helper used to size the credit accumulator.
package vend_pkg;

   // Transaction phases of the controller
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_t;

   // Credit carries one extra bit over a single price/coin so that an
   // overpayment by up to one coin can be represented without wrapping.
   function automatic int credit_width(input int price_w);
      return price_w + 1;
   endfunction

endpackage

// File: rtl/vend_price_table.sv
// Writable price table: NUM_ITEMS registers of PRICE_WIDTH bits each.
// Synchronous write, combinational read. Out-of-range writes are dropped and
// out-of-range reads return 0, which the controller treats as "item disabled".
module vend_price_table
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS       = 16,
   parameter int ITEM_ADDR_WIDTH = 10,
   parameter int PRICE_WIDTH     = 12
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_wr_en,
   input  logic [ITEM_ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [PRICE_WIDTH-1:0]     i_wr_data,
   input  logic [ITEM_ADDR_WIDTH-1:0] i_rd_addr,
   output logic [PRICE_WIDTH-1:0]     o_rd_data
);

   localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam logic [ITEM_ADDR_WIDTH-1:0] LP_DEPTH = ITEM_ADDR_WIDTH'(NUM_ITEMS);

   logic [PRICE_WIDTH-1:0] r_mem [NUM_ITEMS];
   logic                   w_wr_ok;
   logic                   w_rd_ok;

   assign w_wr_ok = i_wr_en && (i_wr_addr < LP_DEPTH);
   assign w_rd_ok = (i_rd_addr < LP_DEPTH);

   // Price storage: cleared on reset, one entry updated per write strobe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
      end
   end

   // Lookup of the currently presented item; invalid addresses read as price 0
   always_comb begin
      o_rd_data = '0;
      if (w_rd_ok) begin
         o_rd_data = r_mem[i_rd_addr[IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending transaction stage. Takes the registered item selection, looks up
// its price, accumulates coin credit, issues a ready/valid dispense request
// and finally a one-cycle change/refund pulse.
// Optional feature: define VEND_TIMEOUT_EN to abort a stalled COLLECT phase
// after TIMEOUT_CYCLES consecutive cycles without a coin.
module vend_controller
   import vend_pkg::*;
#(
   parameter int ITEM_ADDR_WIDTH = 10,
   parameter int NUM_ITEMS       = 16,
   parameter int PRICE_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [ITEM_ADDR_WIDTH-1:0] item_selected,
   input  logic                       selection_valid,
   input  logic                       price_wr_en,
   input  logic [ITEM_ADDR_WIDTH-1:0] price_wr_addr,
   input  logic [PRICE_WIDTH-1:0]     price_wr_data,
   input  logic                       coin_valid,
   input  logic [PRICE_WIDTH-1:0]     coin_value,
   input  logic                       cancel,
   input  logic                       dispense_ready,
   output logic                       dispense_valid,
   output logic [ITEM_ADDR_WIDTH-1:0] dispense_item,
   output logic                       change_valid,
   output logic [PRICE_WIDTH:0]       change_amount,
   output logic                       invalid_item,
   output logic                       busy,
   output logic                       timeout
);

   localparam int CW = credit_width(PRICE_WIDTH);

   vend_state_t                r_state;
   logic [ITEM_ADDR_WIDTH-1:0] r_item;
   logic [PRICE_WIDTH-1:0]     r_price;
   logic [CW-1:0]              r_credit;

   logic [PRICE_WIDTH-1:0]     w_rd_price;
   logic [CW-1:0]              w_sum;
   logic [CW-1:0]              w_excess;
   logic                       w_timeout_hit;
   logic                       w_abort;
   logic                       w_paid;

   // Saturating credit add: an overflow clamps to all-ones instead of wrapping
   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                             input logic [PRICE_WIDTH-1:0] b);
      logic [CW:0] full;
      full = {1'b0, a} + {2'b00, b};
      if (full[CW]) begin
         return '1;
      end
      return full[CW-1:0];
   endfunction

   vend_price_table #(
      .NUM_ITEMS       (NUM_ITEMS),
      .ITEM_ADDR_WIDTH (ITEM_ADDR_WIDTH),
      .PRICE_WIDTH     (PRICE_WIDTH)
   ) u_price_table (
      .clk       (clk),
      .rstn      (rstn),
      .i_wr_en   (price_wr_en),
      .i_wr_addr (price_wr_addr),
      .i_wr_data (price_wr_data),
      .i_rd_addr (item_selected),
      .o_rd_data (w_rd_price)
   );

   // Credit after this cycle's coin (if any), and leftover once the item is paid
   assign w_sum    = coin_valid ? sat_add(r_credit, coin_value) : r_credit;
   assign w_excess = r_credit - {1'b0, r_price};
   assign w_paid   = (w_sum >= {1'b0, r_price});

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] r_to_cnt;

   // The final coinless cycle of the allowed window triggers the abort
   assign w_timeout_hit = (r_state == ST_COLLECT) && !coin_valid &&
                          (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Counts consecutive coinless COLLECT cycles; held at 0 outside COLLECT so
   // every entry into COLLECT starts a fresh window
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_to_cnt <= '0;
      end else if ((r_state != ST_COLLECT) || coin_valid) begin
         r_to_cnt <= '0;
      end else if (!w_timeout_hit) begin
         r_to_cnt <= r_to_cnt + TW'(1);
      end
   end
`else
   // No counter: this compile-time comparison is always false, so COLLECT
   // waits indefinitely and the timeout output stays 0
   assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // A timeout abort behaves exactly like a customer cancel
   assign w_abort = (r_state == ST_COLLECT) && (cancel || w_timeout_hit);

   // Transaction FSM with registered outputs; pulses default low every cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= ST_IDLE;
         r_item         <= '0;
         r_price        <= '0;
         r_credit       <= '0;
         dispense_valid <= 1'b0;
         dispense_item  <= '0;
         change_valid   <= 1'b0;
         change_amount  <= '0;
         invalid_item   <= 1'b0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         invalid_item  <= 1'b0;
         timeout       <= 1'b0;
         change_valid  <= 1'b0;
         change_amount <= '0;

         case (r_state)
            ST_IDLE: begin
               // Disabled and out-of-range items both read as price 0
               if (selection_valid) begin
                  if (w_rd_price == '0) begin
                     invalid_item <= 1'b1;
                  end else begin
                     r_item   <= item_selected;
                     r_price  <= w_rd_price;
                     r_credit <= '0;
                     r_state  <= ST_COLLECT;
                     busy     <= 1'b1;
                  end
               end
            end

            ST_COLLECT: begin
               timeout <= w_timeout_hit;
               if (w_abort) begin
                  r_credit <= '0;
                  if (w_sum != '0) begin
                     change_valid  <= 1'b1;
                     change_amount <= w_sum;
                     r_state       <= ST_CHANGE;
                  end else begin
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end else if (w_paid) begin
                  r_credit       <= w_sum;
                  dispense_valid <= 1'b1;
                  dispense_item  <= r_item;
                  r_state        <= ST_DISPENSE;
               end else begin
                  r_credit <= w_sum;
               end
            end

            ST_DISPENSE: begin
               // dispense_valid is high for the whole of this state
               if (dispense_ready) begin
                  dispense_valid <= 1'b0;
                  r_credit       <= '0;
                  if (w_excess != '0) begin
                     change_valid  <= 1'b1;
                     change_amount <= w_excess;
                     r_state       <= ST_CHANGE;
                  end else begin
                     r_state <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end

            ST_CHANGE: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end

            default: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
